// File: rtl/wash_program_sequencer_pkg.sv
// Shared types for the wash program sequencer: state encoding, program record and program table.
package wash_program_sequencer_pkg;

  localparam int DEF_TIME_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FILL,
    S_WASH,
    S_SPIN,
    S_DRAIN,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [DEF_TIME_W-1:0] wash_t;
    logic [DEF_TIME_W-1:0] spin_t;
    logic [1:0]            rinse;
  } prog_t;

  // Times are in ticks; program 3 has no wash time, so clean is requested as soon as WASH is seen.
  localparam prog_t PROG_TABLE [4] = '{
    '{wash_t: 8'd10, spin_t: 8'd5,  rinse: 2'd0},
    '{wash_t: 8'd30, spin_t: 8'd10, rinse: 2'd1},
    '{wash_t: 8'd60, spin_t: 8'd20, rinse: 2'd2},
    '{wash_t: 8'd0,  spin_t: 8'd20, rinse: 2'd0}
  };

  function automatic prog_t lookup_prog(input logic [1:0] sel);
    return PROG_TABLE[sel];
  endfunction

endpackage

// File: rtl/wash_program_sequencer_if.sv
// User controls, washing_machine feedback and command/status lines of the sequencer.
interface wash_program_sequencer_if;

  logic       go;
  logic [1:0] prog_sel;
  logic       fault_clr;
  logic       door_lock;
  logic       motor_wash;
  logic       motor_spin;
  logic       wm_start;
  logic       wm_clean;
  logic       wm_dry;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] pass_left;

  modport slave (
    input  go, prog_sel, fault_clr, door_lock, motor_wash, motor_spin,
    output wm_start, wm_clean, wm_dry, busy, done, fault, pass_left
  );

  modport master (
    output go, prog_sel, fault_clr, door_lock, motor_wash, motor_spin,
    input  wm_start, wm_clean, wm_dry, busy, done, fault, pass_left
  );

endinterface

// File: rtl/wash_program_sequencer_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; clr restarts the period.
module wash_program_sequencer_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk50m,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/wash_program_sequencer.sv
// Program-level controller for washing_machine: issues start pulses per pass, times wash/spin,
// drives clean/dry and supervises the fill phase with a latched timeout fault.
module wash_program_sequencer
  import wash_program_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_W   = DEF_TIME_W,
  parameter int FILL_TO  = 255
) (
  input  logic                      clk50m,
  input  logic                      rst,
  wash_program_sequencer_if.slave   bus
);

  localparam logic [TIME_W-1:0] TIMER_MAX = '1;
  localparam logic [TIME_W-1:0] FILL_LIM  = TIME_W'(FILL_TO);

  state_t            state;
  state_t            next_state;
  prog_t             sel_prog;
  logic [TIME_W-1:0] wash_q;
  logic [TIME_W-1:0] spin_q;
  logic [1:0]        pass_left_q;
  logic [TIME_W-1:0] timer;
  logic              door_lock_q;
  logic              done_q;
  logic              tick;
  logic              clr;
  logic              door_fall;
  logic              accept;
  logic              next_pass;
  logic              finish;
  logic              abandon;

  assign sel_prog  = lookup_prog(bus.prog_sel);
  assign clr       = (next_state != state);
  assign door_fall = door_lock_q && !bus.door_lock;

  wash_program_sequencer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk50m (clk50m),
    .rst    (rst),
    .clr    (clr),
    .tick   (tick)
  );

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wash_q      <= '0;
      spin_q      <= '0;
      pass_left_q <= '0;
      timer       <= '0;
      door_lock_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= next_state;
      door_lock_q <= bus.door_lock;
      done_q      <= finish;
      if (accept) begin
        wash_q      <= TIME_W'(sel_prog.wash_t);
        spin_q      <= TIME_W'(sel_prog.spin_t);
        pass_left_q <= sel_prog.rinse;
      end else if (next_pass) begin
        pass_left_q <= pass_left_q - 2'd1;
      end else if (abandon) begin
        pass_left_q <= '0;
      end
      // Timer restarts with every state change and saturates instead of wrapping.
      if (clr) begin
        timer <= '0;
      end else if (tick && timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // A falling door_lock while the plant is active means the washing machine reset under us.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    next_pass  = 1'b0;
    finish     = 1'b0;
    abandon    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.go) begin
          accept     = 1'b1;
          next_state = S_START;
        end
      end
      S_START: next_state = S_FILL;
      S_FILL: begin
        if (door_fall)                next_state = S_FAULT;
        else if (bus.motor_wash)      next_state = S_WASH;
        else if (bus.motor_spin)      next_state = S_SPIN;
        else if (timer == FILL_LIM)   next_state = S_FAULT;
      end
      S_WASH: begin
        if (door_fall)                next_state = S_FAULT;
        else if (bus.motor_spin)      next_state = S_SPIN;
      end
      S_SPIN: begin
        if (door_fall)                next_state = S_FAULT;
        else if (!bus.motor_spin)     next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.door_lock) begin
          if (pass_left_q != 2'd0) begin
            next_pass  = 1'b1;
            next_state = S_START;
          end else begin
            finish     = 1'b1;
            next_state = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (bus.fault_clr) begin
          abandon    = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.wm_start  = (state == S_START);
    bus.wm_clean  = (state == S_WASH) && (timer >= wash_q);
    bus.wm_dry    = (state == S_SPIN) && (timer >= spin_q);
    bus.busy      = (state != S_IDLE);
    bus.fault     = (state == S_FAULT);
    bus.done      = done_q;
    bus.pass_left = pass_left_q;
  end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer; the bench plays the washing_machine plant by hand.
module tb_wash_program_sequencer;

  logic clk50m;
  logic rst;
  int   checks;
  int   passed;
  int   start_cnt;
  int   done_cnt;

  wash_program_sequencer_if bus ();

  wash_program_sequencer #(
    .TICK_DIV (4),
    .TIME_W   (8),
    .FILL_TO  (5)
  ) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk50m = 1'b0;
  always #5 clk50m = ~clk50m;

  always @(negedge clk50m) begin
    if (bus.wm_start) start_cnt++;
    if (bus.done)     done_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic drive_go(input logic [1:0] sel);
    bus.prog_sel = sel;
    bus.go       = 1'b1;
    step(1);
    bus.go       = 1'b0;
  endtask

  // Plays one short plant pass starting in S_START; ends one cycle after door_lock drops.
  task automatic run_pass();
    step(1);
    bus.door_lock = 1'b1;
    step(2);
    bus.motor_wash = 1'b1;
    step(11);
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b1;
    step(6);
    bus.motor_spin = 1'b0;
    step(3);
    bus.door_lock = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rst = 1'b1;
    step(2);
    outs = {bus.wm_start, bus.wm_clean, bus.wm_dry, bus.busy, bus.done, bus.fault, bus.pass_left};
    checks++;
    if (outs !== 8'h00) $display("[TB] FAIL reset_outputs: got %0h expected 0", outs);
    else passed++;
    rst = 1'b0;
    step(2);
    checks++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL idle_after_reset busy: got %b expected 0", bus.busy);
    else passed++;
  endtask

  task automatic test_prog0();
    int s0 = start_cnt;
    int d0 = done_cnt;
    drive_go(2'd0);
    checks++;
    if ({bus.wm_start, bus.busy, bus.pass_left} !== 4'b1100)
      $display("[TB] FAIL p0_start: got %b expected 1100", {bus.wm_start, bus.busy, bus.pass_left});
    else passed++;
    step(1);
    checks++;
    if (bus.wm_start !== 1'b0) $display("[TB] FAIL p0_start_width: got %b expected 0", bus.wm_start);
    else passed++;
    bus.door_lock = 1'b1;
    step(3);
    bus.motor_wash = 1'b1;
    step(40);
    checks++;
    if (bus.wm_clean !== 1'b0) $display("[TB] FAIL p0_clean_early: got %b expected 0", bus.wm_clean);
    else passed++;
    step(1);
    checks++;
    if (bus.wm_clean !== 1'b1) $display("[TB] FAIL p0_clean_40: got %b expected 1", bus.wm_clean);
    else passed++;
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b1;
    step(1);
    checks++;
    if (bus.wm_clean !== 1'b0) $display("[TB] FAIL p0_clean_drop: got %b expected 0", bus.wm_clean);
    else passed++;
    step(19);
    checks++;
    if (bus.wm_dry !== 1'b0) $display("[TB] FAIL p0_dry_early: got %b expected 0", bus.wm_dry);
    else passed++;
    step(1);
    checks++;
    if (bus.wm_dry !== 1'b1) $display("[TB] FAIL p0_dry_20: got %b expected 1", bus.wm_dry);
    else passed++;
    bus.motor_spin = 1'b0;
    step(3);
    checks++;
    if ({bus.wm_dry, bus.busy, bus.done} !== 3'b010)
      $display("[TB] FAIL p0_drain_wait: got %b expected 010", {bus.wm_dry, bus.busy, bus.done});
    else passed++;
    bus.door_lock = 1'b0;
    step(1);
    checks++;
    if ({bus.done, bus.busy} !== 2'b10)
      $display("[TB] FAIL p0_done: got %b expected 10", {bus.done, bus.busy});
    else passed++;
    step(1);
    checks++;
    if ({bus.done, start_cnt - s0, done_cnt - d0} !== {1'b0, 32'd1, 32'd1})
      $display("[TB] FAIL p0_counts: done=%b starts=%0d dones=%0d expected 0/1/1",
               bus.done, start_cnt - s0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_multipass();
    int s0 = start_cnt;
    int d0 = done_cnt;
    drive_go(2'd2);
    checks++;
    if (bus.pass_left !== 2'd2) $display("[TB] FAIL p2_pass_left0: got %0d expected 2", bus.pass_left);
    else passed++;
    run_pass();
    checks++;
    if ({bus.wm_start, bus.pass_left, bus.done} !== 4'b1010)
      $display("[TB] FAIL p2_second_start: got %b expected 1010", {bus.wm_start, bus.pass_left, bus.done});
    else passed++;
    run_pass();
    checks++;
    if ({bus.wm_start, bus.pass_left, bus.done} !== 4'b1000)
      $display("[TB] FAIL p2_third_start: got %b expected 1000", {bus.wm_start, bus.pass_left, bus.done});
    else passed++;
    run_pass();
    checks++;
    if ({bus.done, bus.busy} !== 2'b10)
      $display("[TB] FAIL p2_done: got %b expected 10", {bus.done, bus.busy});
    else passed++;
    step(1);
    checks++;
    if (start_cnt - s0 !== 3 || done_cnt - d0 !== 1)
      $display("[TB] FAIL p2_counts: starts=%0d dones=%0d expected 3/1", start_cnt - s0, done_cnt - d0);
    else passed++;
  endtask

  task automatic test_spin_only();
    drive_go(2'd3);
    step(1);
    bus.door_lock  = 1'b1;
    bus.motor_wash = 1'b1;
    step(1);
    checks++;
    if (bus.wm_clean !== 1'b1) $display("[TB] FAIL p3_clean_now: got %b expected 1", bus.wm_clean);
    else passed++;
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b1;
    step(80);
    checks++;
    if (bus.wm_dry !== 1'b0) $display("[TB] FAIL p3_dry_early: got %b expected 0", bus.wm_dry);
    else passed++;
    step(1);
    checks++;
    if (bus.wm_dry !== 1'b1) $display("[TB] FAIL p3_dry_80: got %b expected 1", bus.wm_dry);
    else passed++;
    bus.motor_spin = 1'b0;
    step(1);
    bus.door_lock = 1'b0;
    step(1);
    checks++;
    if (bus.done !== 1'b1) $display("[TB] FAIL p3_done: got %b expected 1", bus.done);
    else passed++;
    step(1);
  endtask

  task automatic test_fill_timeout();
    drive_go(2'd2);
    step(1);
    bus.door_lock = 1'b1;
    step(19);
    checks++;
    if (bus.fault !== 1'b0) $display("[TB] FAIL to_early: got %b expected 0", bus.fault);
    else passed++;
    step(2);
    checks++;
    if ({bus.fault, bus.busy, bus.wm_start, bus.wm_clean, bus.wm_dry, bus.pass_left} !== 7'b1100010)
      $display("[TB] FAIL to_fault: got %b expected 1100010",
               {bus.fault, bus.busy, bus.wm_start, bus.wm_clean, bus.wm_dry, bus.pass_left});
    else passed++;
    bus.go        = 1'b1;
    bus.fault_clr = 1'b1;
    step(1);
    bus.go        = 1'b0;
    bus.fault_clr = 1'b0;
    bus.door_lock = 1'b0;
    checks++;
    if ({bus.fault, bus.busy, bus.pass_left} !== 4'b0000)
      $display("[TB] FAIL to_clear: got %b expected 0000", {bus.fault, bus.busy, bus.pass_left});
    else passed++;
    step(1);
    checks++;
    if ({bus.wm_start, bus.busy} !== 2'b00)
      $display("[TB] FAIL to_go_not_queued: got %b expected 00", {bus.wm_start, bus.busy});
    else passed++;
  endtask

  task automatic test_go_ignored();
    int s0 = start_cnt;
    drive_go(2'd0);
    step(1);
    bus.door_lock = 1'b1;
    step(1);
    bus.motor_wash = 1'b1;
    step(1);
    for (int i = 0; i < 39; i++) begin
      bus.go       = 1'b1;
      bus.prog_sel = 2'(i);
      step(1);
    end
    checks++;
    if (bus.wm_clean !== 1'b0) $display("[TB] FAIL gi_clean_early: got %b expected 0", bus.wm_clean);
    else passed++;
    step(1);
    bus.go = 1'b0;
    checks++;
    if (bus.wm_clean !== 1'b1) $display("[TB] FAIL gi_clean_40: got %b expected 1", bus.wm_clean);
    else passed++;
    checks++;
    if (start_cnt - s0 !== 1) $display("[TB] FAIL gi_starts: got %0d expected 1", start_cnt - s0);
    else passed++;
    bus.prog_sel   = 2'd2;
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b1;
    step(20);
    checks++;
    if (bus.wm_dry !== 1'b0) $display("[TB] FAIL gi_dry_early: got %b expected 0", bus.wm_dry);
    else passed++;
    step(1);
    checks++;
    if (bus.wm_dry !== 1'b1) $display("[TB] FAIL gi_dry_20: got %b expected 1", bus.wm_dry);
    else passed++;
    bus.motor_spin = 1'b0;
    step(1);
    bus.door_lock = 1'b0;
    step(1);
    checks++;
    if ({bus.done, bus.pass_left} !== 3'b100)
      $display("[TB] FAIL gi_done: got %b expected 100", {bus.done, bus.pass_left});
    else passed++;
    step(1);
  endtask

  task automatic test_door_drop();
    drive_go(2'd1);
    checks++;
    if (bus.pass_left !== 2'd1) $display("[TB] FAIL dd_pass_left: got %0d expected 1", bus.pass_left);
    else passed++;
    step(1);
    bus.door_lock = 1'b1;
    step(1);
    bus.motor_wash = 1'b1;
    step(4);
    bus.door_lock  = 1'b0;
    bus.motor_wash = 1'b0;
    step(1);
    checks++;
    if ({bus.fault, bus.busy} !== 2'b11)
      $display("[TB] FAIL dd_fault: got %b expected 11", {bus.fault, bus.busy});
    else passed++;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    checks++;
    if ({bus.fault, bus.busy} !== 2'b00)
      $display("[TB] FAIL dd_clear: got %b expected 00", {bus.fault, bus.busy});
    else passed++;
  endtask

  task automatic test_reset_mid_spin();
    int d0;
    logic [7:0] outs;
    drive_go(2'd1);
    step(1);
    bus.door_lock = 1'b1;
    step(1);
    bus.motor_wash = 1'b1;
    step(1);
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b1;
    step(51);
    checks++;
    if (bus.wm_dry !== 1'b1) $display("[TB] FAIL rs_in_spin: got %b expected 1", bus.wm_dry);
    else passed++;
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    outs = {bus.wm_start, bus.wm_clean, bus.wm_dry, bus.busy, bus.done, bus.fault, bus.pass_left};
    checks++;
    if (outs !== 8'h00) $display("[TB] FAIL rs_outputs: got %0h expected 0", outs);
    else passed++;
    step(1);
    rst            = 1'b0;
    bus.motor_spin = 1'b0;
    bus.door_lock  = 1'b0;
    step(2);
    checks++;
    if (done_cnt !== d0 || bus.busy !== 1'b0)
      $display("[TB] FAIL rs_no_done: dones=%0d busy=%b expected %0d/0", done_cnt, bus.busy, d0);
    else passed++;
    drive_go(2'd0);
    checks++;
    if ({bus.wm_start, bus.pass_left} !== 3'b100)
      $display("[TB] FAIL rs_restart: got %b expected 100", {bus.wm_start, bus.pass_left});
    else passed++;
    run_pass();
    checks++;
    if ({bus.done, bus.busy} !== 2'b10)
      $display("[TB] FAIL rs_restart_done: got %b expected 10", {bus.done, bus.busy});
    else passed++;
    step(1);
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    start_cnt      = 0;
    done_cnt       = 0;
    rst            = 1'b1;
    bus.go         = 1'b0;
    bus.prog_sel   = 2'd0;
    bus.fault_clr  = 1'b0;
    bus.door_lock  = 1'b0;
    bus.motor_wash = 1'b0;
    bus.motor_spin = 1'b0;
    test_reset();
    test_prog0();
    test_multipass();
    test_spin_only();
    test_fill_timeout();
    test_go_ignored();
    test_door_drop();
    test_reset_mid_spin();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
